// File: rtl/cl_pkg.sv
// cl_pkg: opcodes, scheduler state encoding and default width shared by the cl_sched slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cl_pkg;

  // Logic-cell opcodes
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Default operand/result width
  localparam int CL_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/cl_sched_if.sv
// cl_sched_if: request/operand bundle for two requesters plus the grant/result return path.
// Latency: n/a (wiring only).
// Backpressure: req is held by the requester until its gnt pulse.
interface cl_sched_if import cl_pkg::*; #(
  parameter int WIDTH = CL_WIDTH_DEFAULT
);

  logic             req0;
  logic             req1;
  logic [1:0]       op0;
  logic [1:0]       op1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       gnt;
  logic             busy;
  logic [WIDTH-1:0] res;
  logic             res_valid;
  logic             res_id;

  // Requester side
  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1,
    input  gnt, busy, res, res_valid, res_id
  );

  // Scheduler side
  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1,
    output gnt, busy, res, res_valid, res_id
  );

endinterface

// File: rtl/cl.sv
// cl: single-bit logic cell, S selects AND / OR / XOR / NOT a.
// Latency: combinational.
// Backpressure: none.
module cl import cl_pkg::*; (
  output logic       out,
  input  logic       a,
  input  logic       b,
  input  logic [1:0] S
);

  // Pick the boolean function for the presented bit pair; NOT ignores b
  always_comb begin
    out = 1'b0;
    case (S)
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_XOR:  out = a ^ b;
      default: out = ~a;
    endcase
  end

endmodule

// File: rtl/cl_sched.sv
// cl_sched: round-robin scheduler for two requesters sharing one bit-serial logic cell.
// Latency: grant edge + WIDTH edges to res_valid; back-to-back grants every WIDTH+2 cycles.
// Backpressure: a requester holds req/op/a/b until gnt; requests during RUN/DONE wait for IDLE.
module cl_sched import cl_pkg::*; #(
  parameter int WIDTH = CL_WIDTH_DEFAULT
) (
  input logic       clk,
  input logic       reset_n,
  cl_sched_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_id_q, res_id_d;
  logic             res_valid_q, res_valid_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;

  logic any_req;
  logic winner;
  logic cell_out;

  // The one shared cell works on the bit selected by the counter, LSB first
  cl u_cl (
    .out (cell_out),
    .a   (a_q[cnt_q]),
    .b   (b_q[cnt_q]),
    .S   (op_q)
  );

  // Round-robin pick: a lone request wins, a tie goes to whoever was not served last
  always_comb begin
    any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      winner = ~last_q;
    end else begin
      winner = bus.req1;
    end
  end

  // Next-state and registered-output computation for IDLE -> RUN -> DONE
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    last_d      = last_q;
    acc_d       = acc_q;
    res_d       = res_q;
    res_id_d    = res_id_q;
    res_valid_d = 1'b0;
    gnt_d       = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          id_d    = winner;
          last_d  = winner;
          op_d    = winner ? bus.op1 : bus.op0;
          a_d     = winner ? bus.a1  : bus.a0;
          b_d     = winner ? bus.b1  : bus.b0;
          cnt_d   = '0;
          gnt_d   = winner ? 2'b10 : 2'b01;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d[cnt_q] = cell_out;
        if (cnt_q == CNT_LAST) begin
          // Final bit: publish the whole word together with its owner
          res_d       = acc_d;
          res_id_d    = id_q;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and outputs; reset abandons any in-flight operation and favours requester 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      acc_q       <= '0;
      res_q       <= '0;
      res_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
      gnt_q       <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.res       = res_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;

endmodule

// File: doc/cl_sched.md
CL_SCHED -- requirements
Module: cl_sched

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand/result width in bits (legal range 2..16).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit, the reset: asynchronous and active-low.
REQ-004 The module SHALL have ports req0 and req1, input, 1 bit each, the operation requests from requester 0 and requester 1.
REQ-005 The module SHALL have ports op0 and op1, input, 2 bits each, the opcode per requester: 00 AND, 01 OR, 10 XOR, 11 NOT a.
REQ-006 The module SHALL have ports a0, b0, a1 and b1, input, WIDTH bits each, the operands per requester.
REQ-007 The module SHALL have port gnt, output, 2 bits, a one-hot grant, bit i for requester i.
REQ-008 The module SHALL have port busy, output, 1 bit, high whenever the FSM is not IDLE.
REQ-009 The module SHALL have port res, output, WIDTH bits, the last completed result.
REQ-010 The module SHALL have port res_valid, output, 1 bit, a one-cycle completion pulse.
REQ-011 The module SHALL have port res_id, output, 1 bit, the requester that owns res.

Function
REQ-012 The module SHALL implement an FSM with states IDLE, RUN and DONE; grants SHALL occur only in IDLE.
REQ-013 On an edge in IDLE with any req high, the module SHALL:
  - select the winner;
  - latch its op, a, b and id;
  - clear the bit counter;
  - enter RUN;
  - assert gnt[winner] for exactly the following cycle.
REQ-014 The arbitration SHALL be round-robin:
  - a single request wins;
  - with both requests high, the requester not granted last wins;
  - after reset, requester 0 has priority.
REQ-015 A requester SHALL hold req, op, a and b stable until gnt; the module SHALL ignore a req dropped before grant.
REQ-016 In RUN, the module SHALL evaluate one bit per cycle through a single shared logic cell, LSB first.
REQ-017 On each RUN edge k (k = 1..WIDTH after the grant edge), the module SHALL write result bit k-1 into the result register.
REQ-018 For op 11, the module SHALL ignore b.
REQ-019 On edge WIDTH after the grant edge, the module SHALL:
  - write the final bit;
  - enter DONE;
  - update res and res_id;
  - assert res_valid.
REQ-020 res_valid SHALL be high for exactly one cycle; the module SHALL return from DONE to IDLE on the next edge.
REQ-021 res and res_id SHALL hold their values until the next completion.
REQ-022 The counter SHALL count 0..WIDTH-1 and SHALL NOT wrap within one operation.
REQ-023 A req held high continuously SHALL be re-arbitrated in IDLE, so back-to-back grants are spaced WIDTH+2 cycles apart.
REQ-024 A req arriving during RUN or DONE SHALL wait for IDLE; the module SHALL NOT abort the in-flight operation.

Reset
REQ-025 While reset_n is low, the module SHALL immediately force:
  - state IDLE;
  - gnt=00, busy=0;
  - res=0, res_valid=0, res_id=0;
  - counter=0;
  - round-robin pointer set so requester 0 wins next.
REQ-026 A reset during RUN or DONE SHALL abandon the operation with no res_valid pulse; the requester SHALL re-request after reset.

Structure
REQ-027 Shared package cl_pkg SHALL hold:
  - opcode constants OP_AND, OP_OR, OP_XOR, OP_NOT;
  - the FSM state encoding;
  - the default WIDTH.
REQ-028 The module SHALL instantiate the existing cl logic cell exactly once (ports out, a, b, S) as its only sub-module; its output SHALL be registered, never driven to ports directly.

Verification
REQ-029 The bench SHALL check single requester AND: req0, a0=F0, b0=3C, op0=00 -> gnt=01 one cycle; busy for WIDTH+1 cycles; res=30, res_id=0, res_valid pulse 8 cycles after the grant edge.
REQ-030 The bench SHALL check the other opcodes on the same operands: op 01 -> FC; op 10 -> CC; op 11 -> 0F, for both b=3C and b=FF.
REQ-031 The bench SHALL check simultaneous requests after reset: req0 and req1 high, a1=AA, b1=55, op1=10 -> requester 0 served first; then gnt=10 and res=FF, res_id=1.
REQ-032 The bench SHALL check fairness: both reqs held for 4 operations -> grants alternate 0,1,0,1; each grant exactly WIDTH+2 cycles apart.
REQ-033 The bench SHALL check reset mid-RUN: reset_n low 4 cycles after the grant -> busy=0, res=00, no res_valid; a following request completes normally.
REQ-034 The bench SHALL check late arrival: req1 rises during requester 0's RUN -> no gnt until IDLE; then gnt=10.
